// File: rtl/sram_responder_if.sv
// SRAM-style fetch and data port bundle between the CPU and the memory responder.
//   inst_en / inst_addr / inst_rdata : instruction read port
//   data_en / data_wen / data_addr / data_wdata / data_rdata : data load/store port
// master = CPU side (drives requests), slave = memory side (returns read data).
interface sram_responder_if;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;

    modport master (
        output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        input  inst_rdata, data_rdata
    );

    modport slave (
        input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        output inst_rdata, data_rdata
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU fetch and data SRAM ports sharing one word array.
// Reads return one cycle after the request and hold until the next read on that port;
// byte-masked stores commit at the request edge.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : instruction and data request/response signals
//   perf_clr          : synchronous clear of the access counters
//   cnt_ifetch/load/store : saturating access counters
//   err, err_addr     : sticky error flag and virtual address of the first error access
module sram_responder #(
    parameter int          DEPTH = 16384,
    parameter logic [31:0] BASE  = 32'h1fc00000
) (
    input  logic            clk,
    input  logic            rst,
    sram_responder_if.slave bus,
    input  logic            perf_clr,
    output logic [31:0]     cnt_ifetch,
    output logic [31:0]     cnt_load,
    output logic [31:0]     cnt_store,
    output logic            err,
    output logic [31:0]     err_addr
);
    localparam int IW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] phys);
        logic [31:0] off;
        off = phys - BASE;
        return (phys >= BASE) && ((off >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] phys);
        return IW'((phys - BASE) >> 2);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffffffff) ? v : v + 32'd1;
    endfunction

    logic [31:0]   inst_phys, data_phys;
    logic          inst_ok, data_ok;
    logic          data_rd, data_wr;
    logic          inst_err, data_err;
    logic          collide;
    logic [IW-1:0] inst_idx, data_idx;
    logic [31:0]   data_old, data_merged, inst_word;

    always_comb begin
        // kseg0 and kseg1 alias onto the same physical space.
        inst_phys = {3'b000, bus.inst_addr[28:0]};
        data_phys = {3'b000, bus.data_addr[28:0]};
        inst_ok   = in_range(inst_phys) && (bus.inst_addr[1:0] == 2'b00);
        data_ok   = in_range(data_phys) && (bus.data_addr[1:0] == 2'b00);
        inst_idx  = word_idx(inst_phys);
        data_idx  = word_idx(data_phys);
        data_rd   = bus.data_en && (bus.data_wen == 4'b0000);
        data_wr   = bus.data_en && (bus.data_wen != 4'b0000);
        inst_err  = bus.inst_en && !inst_ok;
        data_err  = bus.data_en && !data_ok;

        data_old    = mem[data_idx];
        data_merged = data_old;
        for (int b = 0; b < 4; b++) begin
            if (bus.data_wen[b]) data_merged[8*b +: 8] = bus.data_wdata[8*b +: 8];
        end

        // Fetch of the word being stored this cycle sees the merged (write-first) value.
        collide   = data_wr && data_ok && inst_ok && (inst_idx == data_idx);
        inst_word = collide ? data_merged : mem[inst_idx];
    end

    // Array has no reset; contents come from the preload image.
    always_ff @(posedge clk) begin
        if (!rst && data_wr && data_ok) mem[data_idx] <= data_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.inst_rdata <= '0;
            bus.data_rdata <= '0;
            cnt_ifetch     <= '0;
            cnt_load       <= '0;
            cnt_store      <= '0;
            err            <= 1'b0;
            err_addr       <= '0;
        end else begin
            if (bus.inst_en) bus.inst_rdata <= inst_ok ? inst_word : 32'h0;
            if (data_rd)     bus.data_rdata <= data_ok ? data_old : 32'h0;

            if (perf_clr) begin
                cnt_ifetch <= '0;
                cnt_load   <= '0;
                cnt_store  <= '0;
            end else begin
                if (bus.inst_en) cnt_ifetch <= sat_inc(cnt_ifetch);
                if (data_rd)     cnt_load   <= sat_inc(cnt_load);
                if (data_wr)     cnt_store  <= sat_inc(cnt_store);
            end

            // Only the first error is recorded; the fetch port wins a tie.
            if (!err && (inst_err || data_err)) begin
                err      <= 1'b1;
                err_addr <= inst_err ? bus.inst_addr : bus.data_addr;
            end
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed vector table, multi-cycle corner
// sequences, and a randomized run against an array-based reference model.
module tb_sram_responder;
    localparam logic [31:0] BASE  = 32'h1fc00000;
    localparam int          DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        perf_clr;
    logic [31:0] cnt_ifetch, cnt_load, cnt_store, err_addr;
    logic        err;

    sram_responder_if bus ();

    sram_responder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .perf_clr   (perf_clr),
        .cnt_ifetch (cnt_ifetch),
        .cnt_load   (cnt_load),
        .cnt_store  (cnt_store),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ie;
        logic [31:0] ia;
        logic        de;
        logic [3:0]  wen;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] e_inst;
        logic [31:0] e_data;
        logic [31:0] e_ci;
        logic [31:0] e_cl;
        logic [31:0] e_cs;
        logic        e_err;
        logic [31:0] e_ea;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [31:0] mm [16];
    logic [31:0] m_inst, m_data, m_ci, m_cl, m_cs, m_ea;
    logic        m_err;

    function automatic vec_t mk(input logic ie, input logic [31:0] ia, input logic de,
                                input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                                input logic [31:0] ei, input logic [31:0] ed, input logic [31:0] eci,
                                input logic [31:0] ecl, input logic [31:0] ecs, input logic ee,
                                input logic [31:0] ea);
        vec_t v;
        v.ie = ie; v.ia = ia; v.de = de; v.wen = wen; v.da = da; v.wd = wd;
        v.e_inst = ei; v.e_data = ed; v.e_ci = eci; v.e_cl = ecl; v.e_cs = ecs;
        v.e_err = ee; v.e_ea = ea;
        return v;
    endfunction

    task automatic drive(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                         input logic pc);
        bus.inst_en    = ie;
        bus.inst_addr  = ia;
        bus.data_en    = de;
        bus.data_wen   = wen;
        bus.data_addr  = da;
        bus.data_wdata = wd;
        perf_clr       = pc;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ed,
                             input logic [31:0] eci, input logic [31:0] ecl, input logic [31:0] ecs,
                             input logic ee, input logic [31:0] ea);
        chk({tag, ".inst_rdata"}, bus.inst_rdata, ei);
        chk({tag, ".data_rdata"}, bus.data_rdata, ed);
        chk({tag, ".cnt_ifetch"}, cnt_ifetch, eci);
        chk({tag, ".cnt_load"},   cnt_load,   ecl);
        chk({tag, ".cnt_store"},  cnt_store,  ecs);
        chk({tag, ".err"},        32'(err),   32'(ee));
        chk({tag, ".err_addr"},   err_addr,   ea);
    endtask

    // ---- reference model: plain address arithmetic over a small word array ----
    function automatic logic m_valid(input logic [31:0] a);
        logic [31:0] phys;
        phys = a & 32'h1fffffff;
        return (phys >= BASE) && (phys < BASE + 32'(DEPTH * 4)) && (a % 4 == 0);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(((a & 32'h1fffffff) - BASE) / 4);
    endfunction

    function automatic logic [31:0] m_inc(input logic [31:0] v);
        return (v == 32'hffffffff) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_inst = 0; m_data = 0; m_ci = 0; m_cl = 0; m_cs = 0; m_err = 0; m_ea = 0;
    endtask

    task automatic model_step(input logic ie, input logic [31:0] ia, input logic de,
                              input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                              input logic pc);
        logic iv, dv;
        int   k;
        iv = m_valid(ia);
        dv = m_valid(da);
        if (de && wen != 0 && dv) begin
            k = m_idx(da);
            for (int b = 0; b < 4; b++)
                if (wen[b]) mm[k][8*b +: 8] = wd[8*b +: 8];
        end
        if (ie) m_inst = iv ? mm[m_idx(ia)] : 32'h0;
        if (de && wen == 0) m_data = dv ? mm[m_idx(da)] : 32'h0;
        if (pc) begin
            m_ci = 0; m_cl = 0; m_cs = 0;
        end else begin
            if (ie) m_ci = m_inc(m_ci);
            if (de && wen == 0) m_cl = m_inc(m_cl);
            if (de && wen != 0) m_cs = m_inc(m_cs);
        end
        if (!m_err && ((ie && !iv) || (de && !dv))) begin
            m_err = 1;
            m_ea  = (ie && !iv) ? ia : da;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] phys;
        logic [2:0]  seg;
        int unsigned kind, k;
        kind = $urandom_range(0, 15);
        k    = $urandom_range(0, 15);
        seg  = 3'($urandom_range(0, 7));
        case (kind)
            0:       phys = BASE + 32'(DEPTH * 4) + k * 4;
            1:       phys = BASE - 4 - k * 4;
            2:       phys = BASE + k * 4 + $urandom_range(1, 3);
            default: phys = BASE + k * 4;
        endcase
        return {seg, phys[28:0]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        check_all("reset", 0, 0, 0, 0, 0, 1'b0, 0);
        rst = 1'b0;

        // ---- directed table ----
        vecs.push_back(mk(0, 0, 1, 4'hf, 32'h9fc00010, 32'hdeadbeef, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h1, 32'h9fc00010, 32'h000000aa, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 32'hbfc00010, 0, 0, 32'hdeadbeaa, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 32'hdeadbeaa, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 32'hdeadbeaa, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 32'hdeadbeaa, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hf, 32'hbfc00000, 32'h3c1d0001, 0, 32'hdeadbeaa, 0, 1, 3, 0, 0));
        vecs.push_back(mk(1, 32'hbfc00000, 0, 4'h0, 0, 0, 32'h3c1d0001, 32'hdeadbeaa, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hf, 32'hbfc00020, 32'h55667788, 32'h3c1d0001, 32'hdeadbeaa, 1, 1, 4, 0, 0));
        vecs.push_back(mk(1, 32'hbfc00020, 1, 4'hc, 32'h9fc00020, 32'h12340000, 32'h12347788, 32'hdeadbeaa, 2, 1, 5, 0, 0));
        vecs.push_back(mk(1, 32'h9fc00010, 1, 4'h0, 32'hbfc00020, 0, 32'hdeadbeaa, 32'h12347788, 3, 2, 5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hf, 32'hbfc0fffc, 32'h0badf00d, 32'hdeadbeaa, 32'h12347788, 3, 2, 6, 0, 0));
        vecs.push_back(mk(1, 32'hbfc0fffc, 1, 4'h0, 32'h9fc0fffc, 0, 32'h0badf00d, 32'h0badf00d, 4, 3, 6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 32'hbfc00002, 0, 32'h0badf00d, 0, 4, 4, 6, 1, 32'hbfc00002));
        vecs.push_back(mk(0, 0, 1, 4'hf, 32'h00000000, 32'hffffffff, 32'h0badf00d, 0, 4, 4, 7, 1, 32'hbfc00002));
        vecs.push_back(mk(1, 32'hbfc00000, 0, 4'h0, 0, 0, 32'h3c1d0001, 0, 5, 4, 7, 1, 32'hbfc00002));

        foreach (vecs[i]) begin
            drive(vecs[i].ie, vecs[i].ia, vecs[i].de, vecs[i].wen, vecs[i].da, vecs[i].wd, 1'b0);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_data, vecs[i].e_ci,
                      vecs[i].e_cl, vecs[i].e_cs, vecs[i].e_err, vecs[i].e_ea);
        end

        // ---- reset during a store, then first request after release ----
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 4'hf, 32'hbfc00000, 32'h11111111, 1'b0);
        step();
        check_all("rst_store", 0, 0, 0, 0, 0, 1'b0, 0);
        rst = 1'b0;
        drive(1'b1, 32'hbfc00000, 1'b0, 4'h0, 0, 0, 1'b0);
        step();
        check_all("post_rst_fetch", 32'h3c1d0001, 0, 1, 0, 0, 1'b0, 0);

        // ---- perf_clr concurrent with a fetch ----
        drive(1'b1, 32'hbfc00020, 1'b0, 4'h0, 0, 0, 1'b1);
        step();
        check_all("clr_fetch", 32'h12347788, 0, 0, 0, 0, 1'b0, 0);
        drive(1'b0, 0, 1'b1, 4'h0, 32'hbfc00010, 0, 1'b0);
        step();
        check_all("after_clr", 32'h12347788, 32'hdeadbeaa, 0, 1, 0, 1'b0, 0);

        // ---- both ports err in the first error cycle; later errors do not overwrite ----
        drive(1'b1, 32'hbfc10000, 1'b1, 4'h0, 32'h00000004, 0, 1'b0);
        step();
        check_all("dual_err", 0, 0, 1, 2, 0, 1'b1, 32'hbfc10000);
        drive(1'b0, 0, 1'b1, 4'h0, 32'hbfbffffc, 0, 1'b0);
        step();
        check_all("second_err", 0, 0, 1, 3, 0, 1'b1, 32'hbfc10000);

        // ---- out-of-range stores are dropped, not aliased into the array ----
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        drive(1'b0, 0, 1'b1, 4'hf, 32'hbfc10000, 32'hdeadbeef, 1'b0);
        step();
        check_all("store_above", 0, 0, 0, 0, 1, 1'b1, 32'hbfc10000);
        drive(1'b0, 0, 1'b1, 4'hf, 32'hbfbffffc, 32'hcafef00d, 1'b0);
        step();
        check_all("store_below", 0, 0, 0, 0, 2, 1'b1, 32'hbfc10000);
        drive(1'b1, 32'hbfc00000, 1'b0, 4'h0, 0, 0, 1'b0);
        step();
        chk("no_alias_low", bus.inst_rdata, 32'h3c1d0001);
        drive(1'b1, 32'hbfc0fffc, 1'b0, 4'h0, 0, 0, 1'b0);
        step();
        chk("no_alias_high", bus.inst_rdata, 32'h0badf00d);

        // ---- randomized run against the reference model ----
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 16; k++) begin
            logic [31:0] a, d;
            a = {3'($urandom_range(0, 7)), 29'(BASE + k * 4)};
            d = $urandom;
            drive(1'b0, 0, 1'b1, 4'hf, a, d, 1'b0);
            model_step(1'b0, 0, 1'b1, 4'hf, a, d, 1'b0);
            step();
            check_all($sformatf("init%0d", k), m_inst, m_data, m_ci, m_cl, m_cs, m_err, m_ea);
        end
        for (int n = 0; n < 500; n++) begin
            logic        ie, de, pc;
            logic [3:0]  w;
            logic [31:0] ia, da, wd;
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            ia = rand_addr();
            da = rand_addr();
            wd = $urandom;
            pc = ($urandom_range(0, 15) == 0);
            drive(ie, ia, de, w, da, wd, pc);
            model_step(ie, ia, de, w, da, wd, pc);
            step();
            check_all($sformatf("rnd%0d", n), m_inst, m_data, m_ci, m_cl, m_cs, m_err, m_ea);
        end

        // ---- load counter saturation ----
        idle();
        @(negedge clk);
        force dut.cnt_load = 32'hffffffff;
        #1;
        release dut.cnt_load;
        #1;
        chk("sat_preset", cnt_load, 32'hffffffff);
        drive(1'b0, 0, 1'b1, 4'h0, 32'hbfc00010, 0, 1'b0);
        step();
        chk("sat_hold", cnt_load, 32'hffffffff);
        drive(1'b0, 0, 1'b0, 4'h0, 0, 0, 1'b1);
        step();
        chk("sat_clear", cnt_load, 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU's two SRAM-style ports: it services instruction fetches and data loads/stores from one shared word array. Reads have one-cycle latency with no back-pressure, and byte-masked writes commit at the clock edge. It sits opposite the `mycpu_top` fetch and data ports in simulation and FPGA builds. It also keeps access counters and a sticky error record for bench and debug visibility.

## Interface
- `DEPTH`, 16384: number of 32-bit words in the array (power of two).
- `BASE`, 32'h1fc00000: physical byte address of word 0.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `inst_en`  in  1: instruction read request.
- `inst_addr`  in  32: instruction byte address (virtual).
- `inst_rdata`  out  32: instruction read data.
- `data_en`  in  1: data access request.
- `data_wen`  in  4: byte write enables; `[0]` selects bits 7:0. Zero means read.
- `data_addr`  in  32: data byte address (virtual).
- `data_wdata`  in  32: store data.
- `data_rdata`  out  32: load data.
- `perf_clr`  in  1: synchronous clear of all counters.
- `cnt_ifetch`, `cnt_load`, `cnt_store`  out  32 each: access counters.
- `err`  out  1: sticky error flag.
- `err_addr`  out  32: virtual address of the first error.

## Operation
- **Address translation:** `phys = {3'b000, addr[28:0]}`. This maps kseg0 and kseg1 onto the same physical space.
- **Word index:** `idx = (phys - BASE) >> 2`.
- **Valid access:** `phys >= BASE`, `idx < DEPTH`, and `addr[1:0] == 0`. Anything else is an error access.
- **Instruction port:** on `inst_en`, latch `mem[idx]` into `inst_rdata` at the next edge and increment `cnt_ifetch`. An error access returns 32'h0.
- **Data read:** `data_en & (data_wen == 0)`. Latch `mem[idx]` into `data_rdata` and increment `cnt_load`. An error access returns 0.
- **Data write:** `data_en & (data_wen != 0)`. Write the enabled bytes of `data_wdata` into `mem[idx]`; disabled bytes keep their old value. `data_rdata` is unchanged and `cnt_store` increments. An error write is dropped, and no array byte changes.
- **Read-data hold:** each `*_rdata` holds its last value until the next enabled read on the same port. The CPU samples `data_rdata` one or more cycles after issuing a load, so holding is required.
- **Same-word collision:** instruction read and data write to the same word in the same cycle is write-first. `inst_rdata` gets the merged word: new bytes where `data_wen` is set, old bytes elsewhere.
- **Counters:** 32-bit and saturating at 32'hffffffff. `perf_clr` zeroes them; if it coincides with an access, the clear wins and the result is 0.
- **Error capture:**
  - Any error access on either port sets `err`.
  - On the first error, `err_addr` captures the offending virtual address.
  - If both ports err in the first error cycle, the instruction address is recorded.
  - `err` and `err_addr` are cleared only by `rst`.
- **Reset values:** `rst` drives `inst_rdata`, `data_rdata`, all counters, `err` and `err_addr` to 0. Array contents are NOT altered by reset; preload happens through simulation `$readmemh` or the FPGA init file.
- **Reset priority:** a request presented in the same cycle as `rst` is ignored; no write or count occurs.

## Timing
- Read latency is exactly 1 cycle: request at edge N, data valid after edge N+1, held thereafter.
- Writes commit at the request edge, so a data read of the same word issued in the next cycle returns the new value.
- Every request is accepted every cycle. There is no stall or ready signal, and both ports can be fully active concurrently.
- Counters and `err` update at the same edge as the access.
- Releasing `rst` mid-stream: the first request after `rst` deasserts is serviced normally.

## Test plan
- **Fetch after preload:** preload `mem[0]` = 32'h3c1d0001; `inst_en` @ 32'hbfc00000 → `inst_rdata` = 32'h3c1d0001 one cycle later; `cnt_ifetch` = 1.
- **Byte write then load:** store 32'hdeadbeef with `data_wen` = 4'b1111 @ 32'h9fc00010, then store 32'h000000aa with `data_wen` = 4'b0001 to the same address. Loading 32'hbfc00010 → `data_rdata` = 32'hdeadbeaa; `data_rdata` is unchanged during both stores; `cnt_store` = 2, `cnt_load` = 1.
- **Hold and collision:** load, then idle 3 cycles → `data_rdata` is stable. Same-cycle fetch and store (`data_wen` = 4'b1100, 32'h12340000) to one word holding 32'h55667788 → `inst_rdata` = 32'h12347788.
- **Errors:** load @ 32'hbfc00002 → `data_rdata` = 0, `err` = 1, `err_addr` = 32'hbfc00002. A following store @ 32'h00000000 → dropped, `err_addr` unchanged.
- **Reset and counter control:**
  - `rst` during a store → array word unchanged, all outputs 0.
  - `perf_clr` concurrent with a fetch → `cnt_ifetch` = 0.
  - Forcing `cnt_load` to 32'hffffffff and loading → it stays at 32'hffffffff.
